// File: rtl/demux64_stream.sv
// Purpose : 1-to-2 stream demultiplexer; each accepted word goes to out0 or out1 by in_sel,
// Latency : 1 cycle from accepted push to outN_valid/outN_data (no same-cycle bypass).
// Backpr. : in_ready drops only for the channel whose FIFO is full; never looks at outN_ready.
//
// Ports:
//   clk, rst                       single clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_sel  producer stream plus per-word destination select
//   out0_valid/out0_ready/out0_data   channel 0 consumer stream (FIFO head)
//   out1_valid/out1_ready/out1_data   channel 1 consumer stream (FIFO head)
//   out0_count/out1_count             FIFO occupancy, 0..DEPTH

// Purpose : generic synchronous FIFO, counter-based full/empty, head read combinationally.
// Latency : 1 cycle from write to rd_vld; no write-through bypass.
// Backpr. : wr_rdy = not full (pre-edge state); a pop in the same cycle does not free a slot early.
//
// Ports: clk, rst; wr_vld/wr_rdy/wr_dat write side; rd_vld/rd_rdy/rd_dat read side; count.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wr_en;
    logic             rd_en;

    // Full/empty come from the counter; pointers are free-running mod DEPTH.
    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rptr];
    assign wr_en  = wr_vld && wr_rdy;
    assign rd_en  = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Storage is cleared too so the head reads 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= wr_dat;
                wptr      <= wptr + PW'(1);
            end
            if (rd_en) begin
                rptr <= rptr + PW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// Purpose : route one valid/ready stream to two independently buffered output channels.
// Latency : 1 cycle push-to-visible on the selected channel.
// Backpr. : a full channel stalls only words addressed to it; in_ready is 0 during reset.
module demux64_stream #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,    // power of 2, >= 2
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    out0_count,
    output logic [CW-1:0]    out1_count
);

    logic fifo0_wr_rdy;
    logic fifo1_wr_rdy;
    logic push;

    // Ready depends only on the select and the target FIFO's fill state, so there
    // is no combinational path from the consumers' ready back to the producer.
    assign in_ready = !rst && (in_sel ? fifo1_wr_rdy : fifo0_wr_rdy);
    assign push     = in_valid && in_ready;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push && !in_sel),
        .wr_rdy (fifo0_wr_rdy),
        .wr_dat (in_data),
        .rd_vld (out0_valid),
        .rd_rdy (out0_ready),
        .rd_dat (out0_data),
        .count  (out0_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push && in_sel),
        .wr_rdy (fifo1_wr_rdy),
        .wr_dat (in_data),
        .rd_vld (out1_valid),
        .rd_rdy (out1_ready),
        .rd_dat (out1_data),
        .count  (out1_count)
    );

endmodule

// File: tb/tb_demux64_stream.sv
module tb_demux64_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_sel;
    logic        out0_valid;
    logic        out0_ready;
    logic [63:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [63:0] out1_data;
    logic [1:0]  out0_count;
    logic [1:0]  out1_count;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    demux64_stream dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Occupancy must stay within 0..DEPTH (an underflow wrap would show as 3).
    always @(negedge clk) begin
        if (!done) begin
            chk("cnt0_bound", {63'b0, out0_count <= 2'd2}, 64'd1);
            chk("cnt1_bound", {63'b0, out1_count <= 2'd2}, 64'd1);
        end
    end

    initial begin
        int s0, s1, g0, g1, cyc;
        bit acc;

        // ---------------- reset / idle ----------------
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h5555;
        out0_ready = 1'b0; out1_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_v0", out0_valid, 0);
            chk("rst_v1", out1_valid, 0);
            chk("rst_c0", out0_count, 0);
            chk("rst_c1", out1_count, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();
        chk("post_rst_no_word", out0_valid, 0);

        // ---------------- basic routing ----------------
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hDEADBEEF_00000001;
        #1;
        chk("no_bypass_v0", out0_valid, 0);
        tick();
        chk("route_v0", out0_valid, 1);
        chk("route_d0", out0_data, 64'hDEADBEEF_00000001);
        chk("route_v1_idle", out1_valid, 0);
        in_sel = 1'b1; in_data = 64'h0123456789ABCDEF;
        tick();
        chk("route_v0_one_cycle", out0_valid, 0);
        chk("route_v1", out1_valid, 1);
        chk("route_d1", out1_data, 64'h0123456789ABCDEF);
        in_valid = 1'b0;
        tick();
        chk("route_v1_one_cycle", out1_valid, 0);
        chk("route_v0_quiet", out0_valid, 0);

        // ---------------- independent backpressure ----------------
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 64'hB1;
        tick();
        in_data = 64'hB2;
        tick();
        chk("bp_c1_full", out1_count, 2);
        in_data = 64'hB3;
        #1;
        chk("bp_in_ready_sel1", in_ready, 0);
        tick();
        chk("bp_c1_held", out1_count, 2);
        in_sel = 1'b0; in_data = 64'hA0;
        #1;
        chk("bp_in_ready_sel0", in_ready, 1);
        tick();
        chk("bp_v0", out0_valid, 1);
        chk("bp_d0", out0_data, 64'hA0);
        in_sel = 1'b1; in_data = 64'hB3;
        out1_ready = 1'b1;
        #1;
        chk("bp_no_comb_ready", in_ready, 0);
        chk("bp_head_b1", out1_data, 64'hB1);
        tick();
        chk("bp_head_b2", out1_data, 64'hB2);
        chk("bp_c1_drop", out1_count, 1);
        chk("bp_ready_back", in_ready, 1);
        chk("bp_v0_drained", out0_valid, 0);
        tick();
        chk("bp_head_b3", out1_data, 64'hB3);
        chk("bp_c1_b3", out1_count, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_c1_empty", out1_count, 0);

        // ---------------- simultaneous push/pop at count=1 ----------------
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hAAAA;
        tick();
        chk("pp_c0_a", out0_count, 1);
        chk("pp_d0_a", out0_data, 64'hAAAA);
        out0_ready = 1'b1; in_data = 64'hBBBB;
        tick();
        chk("pp_c0_stays", out0_count, 1);
        chk("pp_d0_b", out0_data, 64'hBBBB);
        in_valid = 1'b0;
        tick();
        chk("pp_c0_empty", out0_count, 0);

        // ---------------- full with pop ----------------
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hC0;
        tick();
        in_data = 64'hD0;
        tick();
        chk("fp_c0_full", out0_count, 2);
        out0_ready = 1'b1; in_data = 64'hE0;
        #1;
        chk("fp_ready_refused", in_ready, 0);
        tick();
        chk("fp_c0_after_pop", out0_count, 1);
        chk("fp_head_d", out0_data, 64'hD0);
        chk("fp_ready_next", in_ready, 1);
        tick();
        chk("fp_c0_one", out0_count, 1);
        chk("fp_head_e", out0_data, 64'hE0);
        in_valid = 1'b0;
        tick();
        chk("fp_c0_empty", out0_count, 0);

        // ---------------- wrap: 10 words per channel, random ready ----------------
        s0 = 0; s1 = 0; g0 = 0; g1 = 0; acc = 1'b1; cyc = 0;
        in_valid = 1'b0;
        while ((g0 < 10 || g1 < 10) && cyc < 3000) begin
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            if (acc || !in_valid) begin
                if (s0 < 10 || s1 < 10) begin
                    if (s0 >= 10)      in_sel = 1'b1;
                    else if (s1 >= 10) in_sel = 1'b0;
                    else               in_sel = 1'($urandom_range(0, 1));
                    in_data  = in_sel ? 64'h2000 + 64'(s1) : 64'h1000 + 64'(s0);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (out0_valid && out0_ready) begin
                chk("wrap_d0", out0_data, 64'h1000 + 64'(g0));
                g0++;
            end
            if (out1_valid && out1_ready) begin
                chk("wrap_d1", out1_data, 64'h2000 + 64'(g1));
                g1++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                if (in_sel) s1++; else s0++;
            end
            tick();
            cyc++;
        end
        chk("wrap_got0", 64'(g0), 64'd10);
        chk("wrap_got1", 64'(g1), 64'd10);
        in_valid = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        chk("wrap_no_extra0", out0_valid, 0);
        chk("wrap_no_extra1", out1_valid, 0);

        // ---------------- mid-operation reset ----------------
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hF0;
        tick();
        in_sel = 1'b1; in_data = 64'hF1;
        tick();
        chk("mr_c0_pre", out0_count, 1);
        chk("mr_c1_pre", out1_count, 1);
        rst = 1'b1; in_sel = 1'b0; in_data = 64'hF2;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        chk("mr_c0", out0_count, 0);
        chk("mr_c1", out1_count, 0);
        chk("mr_v0", out0_valid, 0);
        chk("mr_v1", out1_valid, 0);
        chk("mr_d0", out0_data, 64'd0);
        chk("mr_d1", out1_data, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("mr_v0_stays", out0_valid, 0);
        chk("mr_v1_stays", out1_valid, 0);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 64'hABC;
        tick();
        chk("mr_fresh_v1", out1_valid, 1);
        chk("mr_fresh_d1", out1_data, 64'hABC);
        chk("mr_fresh_c1", out1_count, 1);
        in_valid = 1'b0;
        tick();

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
